conv2d_tap_sequencer: RTL and testbench
=======================================

CONV2D_TAP_SEQUENCER -- requirements
Module: conv2d_tap_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: input/output feature-map width.
REQ-002 SHALL have parameter HEIGHT, default 8: feature-map height.
REQ-003 SHALL have parameter CHANNELS, default 32: input channels.
REQ-004 SHALL have parameter FILTERS, default 64: output filters.
REQ-005 SHALL have parameter K, default 3: square kernel size.
REQ-006 SHALL have parameter PAD, default 1: zero padding on each side.
REQ-007 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-008 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-009 SHALL have port start  input  1  begin a full layer pass when sampled high in IDLE.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port done  output  1  one-cycle pulse at end of layer.
REQ-012 SHALL have port bias_req  output  1  bias fetch strobe for current filter.
REQ-013 SHALL have port bias_row  output  16  current filter index.
REQ-014 SHALL have port tap_valid  output  1  a tap address set is presented.
REQ-015 SHALL have port tap_ready  input  1  MAC datapath accepts current tap.
REQ-016 SHALL have port fm_addr  output  16  input word address c*WIDTH*HEIGHT + in_y*WIDTH + in_x.
REQ-017 SHALL have port kernel_row  output  16  m*K*CHANNELS + n*CHANNELS + c.
REQ-018 SHALL have port kernel_col  output  16  current filter index f.
REQ-019 SHALL have port tap_first  output  1  first issued tap of current output pixel (accumulator clear).
REQ-020 SHALL have port tap_last  output  1  last issued tap of current output pixel (round, bias, ReLU, write).
REQ-021 SHALL have port out_addr  output  16  output word address f*WIDTH*HEIGHT + i*WIDTH + j.

Function
REQ-022 SHALL implement states IDLE, BIAS, RUN, DONE.
REQ-023 SHALL go IDLE->BIAS on start; start SHALL be ignored in any other state.
REQ-024 SHALL hold bias_req high for exactly one cycle in BIAS with bias_row=f, then enter RUN next cycle.
REQ-025 SHALL iterate in RUN, outermost to innermost: i (0..HEIGHT-1), j (0..WIDTH-1), m (0..K-1), n (0..K-1), c (0..CHANNELS-1).
REQ-026 SHALL compute in_y=i+m-PAD, in_x=j+n-PAD; window positions with in_y or in_x outside [0,HEIGHT-1]/[0,WIDTH-1] SHALL be skipped with no tap issued and no idle cycle inserted.
REQ-027 SHALL assert tap_valid on every RUN cycle; counters SHALL advance only on tap_valid && tap_ready.
REQ-028 SHALL hold all tap outputs stable while tap_valid && !tap_ready.
REQ-029 SHALL issue exactly one tap_first and one tap_last per output pixel; tap count per pixel: corner 4*CHANNELS, edge 6*CHANNELS, interior 9*CHANNELS.
REQ-030 SHALL, on accepted tap_last of pixel (HEIGHT-1,WIDTH-1), go to BIAS with f+1 if f<FILTERS-1, else DONE.
REQ-031 SHALL pulse done for one cycle in DONE, then return to IDLE; busy SHALL be low in the cycle after DONE.
REQ-032 SHALL issue per filter 22*22*CHANNELS = 15488 taps at defaults; 991232 taps per layer.
REQ-033 SHALL drive tap_valid, tap_first, tap_last low outside RUN; bias_req low outside BIAS.
REQ-034 SHALL compute all addresses from registered counters (no combinational path from tap_ready to any address output).

Reset
REQ-035 SHALL on rst go to IDLE and clear f,i,j,m,n,c to 0, overriding start and tap_ready in the same cycle.
REQ-036 SHALL drive at reset: busy=0, done=0, bias_req=0, tap_valid=0, tap_first=0, tap_last=0, all address outputs 0.
REQ-037 SHALL abandon an in-progress pass on rst mid-RUN without emitting done.

Verification
REQ-038 start=1 one cycle, tap_ready=1 -> bias_req at cycle 1 with bias_row=0; first tap at cycle 2: fm_addr=0, kernel_row=4*32=128 (m=1,n=1), tap_first=1.
REQ-039 tap_ready=1, filter 0 pixel (0,0) -> exactly 128 taps, last has kernel_row=287, fm_addr=31*64+9=1993, tap_last=1, out_addr=0.
REQ-040 pixel (3,3) of filter 5 -> 288 taps, first fm_addr=2*8+2=18, kernel_row=0, kernel_col=5, out_addr=5*64+27=347.
REQ-041 tap_ready toggled pseudo-randomly over full layer -> 991232 accepted taps, 64 bias_req, 64*64 tap_last, one done pulse; outputs stable during stalls.
REQ-042 start asserted during RUN -> no restart, counters unaffected.
REQ-043 rst asserted at tap 5000 of filter 2 -> next cycle IDLE, busy=0, all outputs 0, no done; fresh start begins at filter 0.

Source files
------------

// File: rtl/conv2d_tap_sequencer_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// conv2d_tap_sequencer_if - control, bias and tap-address bundle  (rev 1.0)
// ------------------------------------------------------------------------
interface conv2d_tap_sequencer_if;
  logic        start;
  logic        busy;
  logic        done;
  logic        bias_req;
  logic [15:0] bias_row;
  logic        tap_valid;
  logic        tap_ready;
  logic [15:0] fm_addr;
  logic [15:0] kernel_row;
  logic [15:0] kernel_col;
  logic        tap_first;
  logic        tap_last;
  logic [15:0] out_addr;

  modport master (
    input  start, tap_ready,
    output busy, done, bias_req, bias_row, tap_valid, fm_addr,
           kernel_row, kernel_col, tap_first, tap_last, out_addr
  );

  modport slave (
    output start, tap_ready,
    input  busy, done, bias_req, bias_row, tap_valid, fm_addr,
           kernel_row, kernel_col, tap_first, tap_last, out_addr
  );
endinterface
`default_nettype wire

// File: rtl/conv2d_tap_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------------
// conv2d_tap_sequencer - walks filters/pixels/in-bounds taps for a MAC
// datapath, skipping padded window positions without bubbles.  (rev 1.0)
// ------------------------------------------------------------------------
module conv2d_tap_sequencer #(
  parameter int WIDTH    = 8,
  parameter int HEIGHT   = 8,
  parameter int CHANNELS = 32,
  parameter int FILTERS  = 64,
  parameter int K        = 3,
  parameter int PAD      = 1
) (
  input  wire logic              clk,
  input  wire logic              rst,
  conv2d_tap_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BIAS = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_busy, r_done, r_bias_req;
  logic [15:0] r_f, r_i, r_j, r_m, r_n, r_ch;

  // Valid kernel offsets for an output coordinate form one contiguous range,
  // so iterating lo..hi skips padding without ever burning a cycle.
  function automatic logic [15:0] win_lo(input logic [15:0] pos);
    int p = int'(pos);
    return (p < PAD) ? 16'(PAD - p) : 16'd0;
  endfunction

  function automatic logic [15:0] win_hi(input logic [15:0] pos, input int size);
    int p = int'(pos);
    return (p + K - 1 - PAD > size - 1) ? 16'(size - 1 + PAD - p) : 16'(K - 1);
  endfunction

  logic [15:0] w_m_lo, w_m_hi, w_n_lo, w_n_hi, w_m_lo_next, w_n_lo_next;
  logic        w_ch_last, w_n_last, w_m_last, w_j_last, w_i_last, w_f_last, w_run;
  int          w_in_y, w_in_x, w_fm, w_krow, w_oaddr;

  assign w_m_lo      = win_lo(r_i);
  assign w_m_hi      = win_hi(r_i, HEIGHT);
  assign w_n_lo      = win_lo(r_j);
  assign w_n_hi      = win_hi(r_j, WIDTH);
  assign w_m_lo_next = win_lo(r_i + 16'd1);
  assign w_n_lo_next = win_lo(r_j + 16'd1);

  assign w_ch_last = (r_ch == 16'(CHANNELS - 1));
  assign w_n_last  = (r_n == w_n_hi);
  assign w_m_last  = (r_m == w_m_hi);
  assign w_j_last  = (r_j == 16'(WIDTH - 1));
  assign w_i_last  = (r_i == 16'(HEIGHT - 1));
  assign w_f_last  = (r_f == 16'(FILTERS - 1));
  assign w_run     = (r_state == S_RUN);

  assign w_in_y  = int'(r_i) + int'(r_m) - PAD;
  assign w_in_x  = int'(r_j) + int'(r_n) - PAD;
  assign w_fm    = int'(r_ch) * WIDTH * HEIGHT + w_in_y * WIDTH + w_in_x;
  assign w_krow  = int'(r_m) * K * CHANNELS + int'(r_n) * CHANNELS + int'(r_ch);
  assign w_oaddr = int'(r_f) * WIDTH * HEIGHT + int'(r_i) * WIDTH + int'(r_j);

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.bias_req   = r_bias_req;
  assign bus.bias_row   = r_f;
  assign bus.tap_valid  = w_run;
  assign bus.tap_first  = w_run && (r_m == w_m_lo) && (r_n == w_n_lo) && (r_ch == 16'd0);
  assign bus.tap_last   = w_run && w_ch_last && w_n_last && w_m_last;
  assign bus.fm_addr    = w_run ? 16'(w_fm)    : 16'd0;
  assign bus.kernel_row = w_run ? 16'(w_krow)  : 16'd0;
  assign bus.kernel_col = w_run ? r_f          : 16'd0;
  assign bus.out_addr   = w_run ? 16'(w_oaddr) : 16'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_bias_req <= 1'b0;
      r_f  <= 16'd0; r_i <= 16'd0; r_j  <= 16'd0;
      r_m  <= 16'd0; r_n <= 16'd0; r_ch <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_BIAS;
            r_busy     <= 1'b1;
            r_bias_req <= 1'b1;
          end
        end
        S_BIAS: begin
          r_state    <= S_RUN;
          r_bias_req <= 1'b0;
          r_i  <= 16'd0;
          r_j  <= 16'd0;
          r_ch <= 16'd0;
          r_m  <= win_lo(16'd0);
          r_n  <= win_lo(16'd0);
        end
        S_RUN: begin
          if (bus.tap_ready) begin
            if (!w_ch_last) begin
              r_ch <= r_ch + 16'd1;
            end else begin
              r_ch <= 16'd0;
              if (!w_n_last) begin
                r_n <= r_n + 16'd1;
              end else if (!w_m_last) begin
                r_m <= r_m + 16'd1;
                r_n <= w_n_lo;
              end else if (!w_j_last) begin
                r_j <= r_j + 16'd1;
                r_m <= w_m_lo;
                r_n <= w_n_lo_next;
              end else if (!w_i_last) begin
                r_i <= r_i + 16'd1;
                r_j <= 16'd0;
                r_m <= w_m_lo_next;
                r_n <= win_lo(16'd0);
              end else if (!w_f_last) begin
                r_f        <= r_f + 16'd1;
                r_state    <= S_BIAS;
                r_bias_req <= 1'b1;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_f  <= 16'd0; r_i <= 16'd0; r_j  <= 16'd0;
          r_m  <= 16'd0; r_n <= 16'd0; r_ch <= 16'd0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv2d_tap_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_conv2d_tap_sequencer - random-stall scoreboard bench against a
// loop-nest reference of the convolution tap order.  (rev 1.0)
// ------------------------------------------------------------------------
module tb_conv2d_tap_sequencer;
  localparam int W = 5, H = 4, C = 2, F = 3, KK = 3, P = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv2d_tap_sequencer_if bus();

  conv2d_tap_sequencer #(
    .WIDTH(W), .HEIGHT(H), .CHANNELS(C), .FILTERS(F), .K(KK), .PAD(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic [15:0] fm;
    logic [15:0] krow;
    logic [15:0] kcol;
    logic [15:0] oaddr;
    logic        first;
    logic        last;
  } tap_t;

  tap_t exp_q[$];
  int   bias_q[$];
  int   tests = 0, fails = 0;
  int   accepted = 0, dones = 0;
  int   ready_pct = 100;
  bit   stall_prev = 1'b0, prev_done = 1'b0;
  tap_t saved;

  function automatic void check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic bit in_map(input int y, input int x);
    return (y >= 0) && (y < H) && (x >= 0) && (x < W);
  endfunction

  // Reference: plain loop nest over every window position, keeping in-bounds ones.
  task automatic push_layer();
    for (int f = 0; f < F; f++) begin
      bias_q.push_back(f);
      for (int i = 0; i < H; i++)
        for (int j = 0; j < W; j++) begin
          int total = 0, k = 0;
          for (int m = 0; m < KK; m++)
            for (int n = 0; n < KK; n++)
              if (in_map(i + m - P, j + n - P)) total += C;
          for (int m = 0; m < KK; m++)
            for (int n = 0; n < KK; n++)
              for (int c = 0; c < C; c++) begin
                int iy = i + m - P, ix = j + n - P;
                if (in_map(iy, ix)) begin
                  tap_t t;
                  t.fm    = 16'(c * W * H + iy * W + ix);
                  t.krow  = 16'(m * KK * C + n * C + c);
                  t.kcol  = 16'(f);
                  t.oaddr = 16'(f * W * H + i * W + j);
                  t.first = (k == 0);
                  t.last  = (k == total - 1);
                  exp_q.push_back(t);
                  k++;
                end
              end
        end
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      tap_t cur;
      cur = {bus.fm_addr, bus.kernel_row, bus.kernel_col, bus.out_addr,
             bus.tap_first, bus.tap_last};
      if (stall_prev && bus.tap_valid)
        check("stall_hold", longint'(cur != saved), 0);
      stall_prev = bus.tap_valid && !bus.tap_ready;
      saved      = cur;

      if (bus.tap_valid && bus.tap_ready) begin
        accepted++;
        if (exp_q.size() == 0) begin
          check("tap_unexpected", 1, 0);
        end else begin
          tap_t e;
          e = exp_q.pop_front();
          check("fm_addr",    longint'(bus.fm_addr),    longint'(e.fm));
          check("kernel_row", longint'(bus.kernel_row), longint'(e.krow));
          check("kernel_col", longint'(bus.kernel_col), longint'(e.kcol));
          check("out_addr",   longint'(bus.out_addr),   longint'(e.oaddr));
          check("tap_first",  longint'(bus.tap_first),  longint'(e.first));
          check("tap_last",   longint'(bus.tap_last),   longint'(e.last));
        end
      end

      if (bus.bias_req) begin
        if (bias_q.size() == 0) check("bias_unexpected", 1, 0);
        else check("bias_row", longint'(bus.bias_row), longint'(bias_q.pop_front()));
      end

      check("valid_exclusive", longint'(bus.tap_valid && (bus.bias_req || bus.done)), 0);
      check("busy_cover", longint'((bus.tap_valid || bus.bias_req || bus.done) && !bus.busy), 0);
      if (prev_done) begin
        check("done_one_cycle", longint'(bus.done), 0);
        check("busy_after_done", longint'(bus.busy), 0);
      end
      prev_done = bus.done;
      if (bus.done) dones++;
    end else begin
      stall_prev = 1'b0;
      prev_done  = 1'b0;
    end
  end

  initial begin
    bus.tap_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 bus.tap_ready = (int'($urandom_range(0, 99)) < ready_pct);
    end
  end

  task automatic check_reset_outputs(input string name);
    check(name, longint'({bus.busy, bus.done, bus.bias_req, bus.tap_valid,
                          bus.tap_first, bus.tap_last}), 0);
    check({name, "_addr"}, longint'({bus.bias_row, bus.fm_addr, bus.kernel_row, bus.kernel_col})
                           | longint'(bus.out_addr), 0);
  endtask

  task automatic kick_start();
    @(posedge clk); #1 bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    check("bias_after_start", longint'(bus.bias_req), 1);
  endtask

  task automatic run_pass(input int pct, input bit poke_start);
    int d0 = dones;
    bit finished = 1'b0;
    ready_pct = pct;
    push_layer();
    kick_start();
    for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
      @(posedge clk); #1;
      if (dones > d0) finished = 1'b1;
      bus.start = poke_start && !finished && ($urandom_range(0, 15) == 0);
    end
    bus.start = 1'b0;
    check("pass_done_count", dones - d0, 1);
    check("tap_queue_drained", exp_q.size(), 0);
    check("bias_queue_drained", bias_q.size(), 0);
    @(posedge clk); #1;
    check("idle_after_pass", longint'(bus.busy), 0);
  endtask

  task automatic run_reset_midway(input int pct, input int taps);
    int d0 = dones, a0 = accepted;
    bit reached = 1'b0;
    ready_pct = pct;
    push_layer();
    kick_start();
    for (int cyc = 0; cyc < 20000 && !reached; cyc++) begin
      @(posedge clk); #1;
      if (accepted - a0 >= taps) reached = 1'b1;
    end
    check("reset_point_reached", longint'(reached), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrun_reset_outputs");
    rst = 1'b0;
    exp_q.delete();
    bias_q.delete();
    repeat (5) @(posedge clk);
    #1;
    check("no_done_after_abort", dones - d0, 0);
    check("idle_after_abort", longint'(bus.busy), 0);
  endtask

  initial begin
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_outputs");
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("idle_outputs");

    run_pass(100, 1'b0);
    run_pass(60, 1'b1);
    run_reset_midway(70, 2 * 260 + 50);
    run_pass(35, 1'b1);

    check("total_done_pulses", dones, 3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d", tests);
    $fatal(1);
  end

endmodule
`default_nettype wire
